// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter: round-robin, burst-granular arbiter that shares the
// write port of the async FIFO among NUM_REQ requesters in the write clock
// domain. A grant lasts for one burst. The burst ends on Last_in, after
// MAX_BURST words, or when the requester withdraws. Full_in stalls the burst.
module afifo_wr_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 4,
    parameter int REQ_WIDTH   = 2,
    parameter int MAX_BURST   = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic                          Clk,
    input  logic                          Clear_in,
    input  logic [NUM_REQ-1:0]            Req_in,
    input  logic [NUM_REQ-1:0]            Last_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
    output logic [NUM_REQ-1:0]            Ack_out,
    output logic [NUM_REQ-1:0]            Grant_out,
    output logic [REQ_WIDTH-1:0]          Grant_idx_out,
    output logic                          Busy_out,
    output logic [DATA_WIDTH-1:0]         Fifo_Data_out,
    output logic                          Fifo_WriteEn_out,
    input  logic                          Fifo_Full_in
);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t                   r_state;
    logic [NUM_REQ-1:0]       r_grant;
    logic [REQ_WIDTH-1:0]     r_grant_idx;
    logic [REQ_WIDTH-1:0]     r_last;
    logic [BURST_WIDTH-1:0]   r_cnt;

    logic                     w_found;
    logic [REQ_WIDTH-1:0]     w_pick;
    logic [REQ_WIDTH:0]       w_cand;
    logic                     w_req_g;
    logic                     w_last_g;
    logic [DATA_WIDTH-1:0]    w_gdata;
    logic                     w_busy;
    logic                     w_xfer;
    logic                     w_exit;

    // Round-robin pick: first requester at or after last_winner+1, with wrap
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + (REQ_WIDTH+1)'(k);
            if (w_cand >= (REQ_WIDTH+1)'(NUM_REQ))
                w_cand = w_cand - (REQ_WIDTH+1)'(NUM_REQ);
            if (!w_found && Req_in[w_cand[REQ_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[REQ_WIDTH-1:0];
            end
        end
    end

    // Select the granted requester's request, last flag and data via the one-hot grant
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i])
                w_gdata = Data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_req_g  = |(Req_in & r_grant);
    assign w_last_g = |(Last_in & r_grant);
    assign w_busy   = (r_state == S_BURST);

    // A word moves only while bursting, requested, not full and not clearing
    assign w_xfer = w_busy & w_req_g & ~Fifo_Full_in & ~Clear_in;
    assign w_exit = (w_xfer & (w_last_g | (r_cnt == BURST_WIDTH'(MAX_BURST-1))))
                  | (~w_req_g & ~Fifo_Full_in);

    assign Ack_out          = w_xfer ? r_grant : '0;
    assign Fifo_WriteEn_out = w_xfer;
    assign Fifo_Data_out    = (w_busy && !Clear_in) ? w_gdata : '0;
    assign Grant_out        = r_grant;
    assign Grant_idx_out    = r_grant_idx;
    assign Busy_out         = w_busy;

    // Arbitration FSM: IDLE picks a winner, BURST forwards until an end condition
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_last      <= REQ_WIDTH'(NUM_REQ-1);
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_BURST;
                        r_grant     <= NUM_REQ'(1) << w_pick;
                        r_grant_idx <= w_pick;
                        r_cnt       <= '0;
                    end
                end
                S_BURST: begin
                    if (w_exit) begin
                        r_state     <= S_IDLE;
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                        r_last      <= r_grant_idx;
                        r_cnt       <= '0;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter. Inputs change on the falling edge,
// outputs are checked 1 ns later, state advances on the rising edge.
module tb_afifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req, last;
    logic [31:0] data;
    logic [3:0]  ack, grant;
    logic [1:0]  gidx;
    logic        busy, we, full;
    logic [7:0]  fdata;

    logic [3:0]  req2, last2;
    logic [31:0] data2;
    logic [3:0]  ack2, grant2;
    logic [1:0]  gidx2;
    logic        busy2, we2, full2;
    logic [7:0]  fdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    afifo_wr_arbiter u_dut (
        .Clk(clk), .Clear_in(clr), .Req_in(req), .Last_in(last), .Data_in(data),
        .Ack_out(ack), .Grant_out(grant), .Grant_idx_out(gidx), .Busy_out(busy),
        .Fifo_Data_out(fdata), .Fifo_WriteEn_out(we), .Fifo_Full_in(full)
    );

    afifo_wr_arbiter #(.MAX_BURST(2)) u_dut2 (
        .Clk(clk), .Clear_in(clr), .Req_in(req2), .Last_in(last2), .Data_in(data2),
        .Ack_out(ack2), .Grant_out(grant2), .Grant_idx_out(gidx2), .Busy_out(busy2),
        .Fifo_Data_out(fdata2), .Fifo_WriteEn_out(we2), .Fifo_Full_in(full2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full check of one cycle of the main instance
    task automatic chk_all(input string tag, input logic [3:0] e_grant, input logic [1:0] e_idx,
                           input logic e_busy, input logic e_we, input logic [3:0] e_ack,
                           input logic [7:0] e_data);
        chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
        chk({tag, ".idx"},   32'(gidx),  32'(e_idx));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
        chk({tag, ".we"},    32'(we),    32'(e_we));
        chk({tag, ".ack"},   32'(ack),   32'(e_ack));
        chk({tag, ".data"},  32'(fdata), 32'(e_data));
    endtask

    // Check of a stalled or non-writing burst cycle (data is don't-care)
    task automatic chk_nowr(input string tag, input logic [3:0] e_grant, input logic e_busy);
        chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
        chk({tag, ".we"},    32'(we),    32'h0);
        chk({tag, ".ack"},   32'(ack),   32'h0);
    endtask

    initial begin
        clr = 1'b1; req = '0; last = '0; data = '0; full = 1'b0;
        req2 = '0; last2 = '0; data2 = {8'h33, 8'h22, 8'h11, 8'h00}; full2 = 1'b0;

        // Reset cycles: outputs quiet even with a request present
        @(negedge clk); req = 4'b0001; data[7:0] = 8'h55; #1;
        chk_all("rst0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); #1;
        chk_all("rst1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        // Test 1: req0 and req2, max-length bursts
        @(negedge clk); clr = 1'b0; req = 4'b0101; data[7:0] = 8'hA0; data[23:16] = 8'hC0; #1;
        chk_all("t1.idle0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); data[7:0] = 8'hA0 + 8'(k); #1;
            chk_all($sformatf("t1.r0w%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'hA0 + 8'(k));
        end
        @(negedge clk); #1;
        chk_all("t1.idle1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); data[23:16] = 8'hC0 + 8'(k); #1;
            chk_all($sformatf("t1.r2w%0d", k), 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, 8'hC0 + 8'(k));
        end
        @(negedge clk); req = 4'b0000; #1;
        chk_all("t1.idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        // Test 2: req1 alone, Last on the third word
        @(negedge clk); req = 4'b0010; data[15:8] = 8'hB0; #1;
        chk_all("t2.idle0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); data[15:8] = 8'hB0 + 8'(k); last = (k == 2) ? 4'b0010 : 4'b0000; #1;
            chk_all($sformatf("t2.w%0d", k), 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010, 8'hB0 + 8'(k));
        end
        @(negedge clk); last = 4'b0000; #1;
        chk_all("t2.idle1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); req = 4'b0000; #1;
        // Re-granted after one IDLE cycle, then withdrawn with zero words
        chk_nowr("t2.regrant", 4'b0010, 1'b1);
        @(negedge clk); #1;
        chk_all("t2.idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        // Test 3: req3 5-word burst stalled by Full for three cycles
        @(negedge clk); req = 4'b1000; data[31:24] = 8'hD0; #1;
        chk_all("t3.idle0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); #1;
        chk_all("t3.w0", 4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000, 8'hD0);
        @(negedge clk); data[31:24] = 8'hD1; full = 1'b1; #1;
        chk_nowr("t3.st0", 4'b1000, 1'b1);
        @(negedge clk); req = 4'b0000; #1;
        chk_nowr("t3.st1", 4'b1000, 1'b1);
        @(negedge clk); req = 4'b1000; #1;
        chk_nowr("t3.st2", 4'b1000, 1'b1);
        full = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); data[31:24] = 8'hD0 + 8'(k); last = (k == 4) ? 4'b1000 : 4'b0000; #1;
            chk_all($sformatf("t3.w%0d", k), 4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000, 8'hD0 + 8'(k));
        end
        @(negedge clk); last = 4'b0000; req = 4'b0000; #1;
        chk_all("t3.idle1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        // Test 4: req2 withdraws after one word, pending req0 wins next
        @(negedge clk); req = 4'b0100; data[23:16] = 8'hE0; data[7:0] = 8'h70; #1;
        chk_all("t4.idle0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); req = 4'b0101; #1;
        chk_all("t4.w0", 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, 8'hE0);
        @(negedge clk); req = 4'b0001; #1;
        chk_nowr("t4.wd", 4'b0100, 1'b1);
        @(negedge clk); #1;
        chk_all("t4.idle1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); last = 4'b0001; #1;
        chk_all("t4.r0", 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h70);
        @(negedge clk); last = 4'b0000; req = 4'b0000; #1;
        chk_all("t4.idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        // Test 5: Clear mid-burst of req1
        @(negedge clk); req = 4'b0010; data[15:8] = 8'h90; #1;
        chk_all("t5.idle0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); #1;
        chk_all("t5.w0", 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010, 8'h90);
        @(negedge clk); clr = 1'b1; data[15:8] = 8'h91; #1;
        chk("t5.clr.we",   32'(we),    32'h0);
        chk("t5.clr.ack",  32'(ack),   32'h0);
        chk("t5.clr.data", 32'(fdata), 32'h0);
        @(negedge clk); clr = 1'b0; req = 4'b0011; #1;
        chk_all("t5.post", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        @(negedge clk); req = 4'b0000; #1;
        chk_nowr("t5.rearb", 4'b0001, 1'b1);
        @(negedge clk); #1;
        chk_all("t5.idle1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        // Test 6: MAX_BURST=2 instance, all four requesting continuously
        @(negedge clk); req2 = 4'b1111; #1;
        chk("t6.idle.busy", 32'(busy2), 32'h0);
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 2; w++) begin
                @(negedge clk); #1;
                chk($sformatf("t6.b%0dw%0d.grant", b, w), 32'(grant2), 32'(4'b0001 << (b % 4)));
                chk($sformatf("t6.b%0dw%0d.we", b, w),    32'(we2),    32'h1);
                chk($sformatf("t6.b%0dw%0d.data", b, w),  32'(fdata2), 32'(8'h11 * (b % 4)));
            end
            @(negedge clk); #1;
            chk($sformatf("t6.b%0d.gap", b), 32'({busy2, we2, grant2}), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/afifo_wr_arbiter.md
# afifo_wr_arbiter

Round-robin, burst-granular write arbiter sharing the single write port of the asynchronous FIFO among NUM_REQ requesters in the FIFO write-clock domain. It grants one requester at a time and forwards that requester's words to the FIFO write port until the burst ends. Bursts end on `Last_in`, on MAX_BURST words, or on request withdrawal. FIFO `Full_out` back-pressure stalls the burst without dropping data.

## Interface
- `DATA_WIDTH`, 8, FIFO word width.
- `NUM_REQ`, 4, number of requesters (2..16).
- `REQ_WIDTH`, 2, index width, ceil(log2(NUM_REQ)).
- `MAX_BURST`, 8, maximum words per grant (1..2^BURST_WIDTH).
- `BURST_WIDTH`, 4, width of the burst word counter.
- `Clk`  in  1  FIFO write clock (same net as FIFO `WClk`).
- `Clear_in`  in  1  reset, synchronous, active-high.
- `Req_in`  in  NUM_REQ  requester i has a valid word on its `Data_in` slice.
- `Last_in`  in  NUM_REQ  requester i's current word is the last of its burst.
- `Data_in`  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- `Ack_out`  out  NUM_REQ  word of requester i written this cycle; requester advances on it.
- `Grant_out`  out  NUM_REQ  registered one-hot grant.
- `Grant_idx_out`  out  REQ_WIDTH  index of granted requester (0 when idle).
- `Busy_out`  out  1  FSM in BURST.
- `Fifo_Data_out`  out  DATA_WIDTH  to FIFO `Data_in`.
- `Fifo_WriteEn_out`  out  1  to FIFO `WriteEn_in`.
- `Fifo_Full_in`  in  1  from FIFO `Full_out`.

## Operation
- State: FSM {IDLE, BURST}, one-hot grant register, last-winner pointer, burst counter.
- Reset values: FSM=IDLE, `Grant_out`=0, `Grant_idx_out`=0, `Busy_out`=0, burst counter=0, last-winner=NUM_REQ-1, so requester 0 has top priority.
- While `Clear_in`=1: `Ack_out`=0, `Fifo_WriteEn_out`=0, `Fifo_Data_out`=0. This holds even in the reset cycle itself. Clear mid-burst abandons the burst; no write occurs in that cycle.
- IDLE: if any `Req_in` bit is set, pick the first requesting index scanning (last_winner+1) mod NUM_REQ upward with wrap. Load the grant, go to BURST, clear the counter. Nothing is written in an IDLE cycle.
- BURST, granted g:
  - xfer = `Req_in`[g] & ~`Fifo_Full_in`.
  - `Ack_out`[g] = xfer; all other `Ack_out` bits are 0.
  - `Fifo_WriteEn_out` = xfer.
  - `Fifo_Data_out` = `Data_in` slice g, driven whenever granted (don't-care when xfer=0); 0 in IDLE.
  - xfer increments the counter (BURST_WIDTH bits, never wraps inside a burst).
- BURST exit to IDLE at end of cycle, with last-winner := g and grant cleared:
  - (a) xfer & `Last_in`[g];
  - (b) xfer & counter == MAX_BURST-1, i.e. MAX_BURST-th word;
  - (c) `Req_in`[g]=0 & `Fifo_Full_in`=0 (withdrawal; zero words is legal).
- `Fifo_Full_in`=1 stalls: grant held, counter held, no exit, regardless of `Req_in`[g].
- `Req_in`/`Last_in` of non-granted requesters are ignored during BURST.
- Ack, write enable and data are combinational from registered grant plus `Req_in`/`Fifo_Full_in`; no combinational path from `Req_in` to `Grant_out`.

## Timing
- Request at cycle n in IDLE → `Grant_out` at n+1 → first write at n+1 if not full.
- Throughput in BURST: one word per cycle while not full.
- Exactly one IDLE cycle between consecutive bursts; k-word burst occupies k+1 cycles minimum.
- Full rising at cycle m blocks the write at m (FIFO `Full_out` is registered in the `WClk` domain, matching this clock); the next write happens the cycle after Full falls.
- Round-robin fairness: with all requesters continuously requesting, each is granted once per NUM_REQ bursts.

## Test plan
- Reset then `Req_in`=4'b0101, no Last, Full=0 → grant req0 for 8 words (cycles 1..8), IDLE, then req2 for 8 words. `Fifo_Data_out` matches slices, one Ack per word.
- req1 alone, `Last_in`[1] on 3rd word → 3 writes, `Busy_out` drops, next grant of req1 only after one IDLE cycle.
- req3 granted, Full=1 for words 2..4 of a 5-word burst → `Fifo_WriteEn_out`/`Ack_out` low during Full, grant held, 5 words total, order preserved.
- All four requesting continuously with MAX_BURST=2 → grant order 0,1,2,3,0,… each burst exactly 2 writes.
- req2 drops `Req_in` after 1 word with Full=0 → burst ends, last-winner=2, pending req0 granted next.
- `Clear_in` pulsed mid-burst of req1 → no write that cycle; next cycle all outputs at reset values; re-arbitration starts from req0.
